// File: rtl/drain_pkg.sv
// rtl/drain_pkg.sv - shared opcode and drain FSM state types
package drain_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_HOLD = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam int WAIT_W = 3;

endpackage

// File: rtl/lifo_drain_ctrl.sv
// rtl/lifo_drain_ctrl.sv - pops N words from the stack into a valid/ready output register
module lifo_drain_ctrl
    import drain_pkg::*;
#(
    parameter int DinLENGTH = 32,
    parameter int LIFO_Size = 4,
    parameter int POP_LAT   = 1,
    localparam int CW       = $clog2(LIFO_Size + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CW-1:0]        count,
    input  logic                 empty,
    input  logic                 full,
    input  logic [DinLENGTH-1:0] lifo_dout,
    output logic [1:0]           opcode,
    output logic [DinLENGTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 busy_full,
    output logic                 done,
    output logic                 underflow
);

    state_t                 state_q, state_d;
    opcode_t                opcode_q, opcode_d;
    logic [CW-1:0]          remaining_q, remaining_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic                   uflow_q, uflow_d;
    logic [DinLENGTH-1:0]   m_data_q, m_data_d;
    logic                   m_valid_q, m_valid_d;
    logic                   done_q, done_d;
    logic                   underflow_q, underflow_d;
    logic                   busy_full_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            opcode_q    <= OP_IDLE;
            remaining_q <= '0;
            wait_q      <= '0;
            uflow_q     <= 1'b0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
            busy_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            remaining_q <= remaining_d;
            wait_q      <= wait_d;
            uflow_q     <= uflow_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            done_q      <= done_d;
            underflow_q <= underflow_d;
            busy_full_q <= full;
        end
    end

    always_comb begin
        state_d     = state_q;
        opcode_d    = OP_IDLE;
        remaining_d = remaining_q;
        wait_d      = wait_q;
        uflow_d     = uflow_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        done_d      = 1'b0;
        underflow_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        remaining_d = count;
                        state_d     = ST_ISSUE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                // The POP was committed into opcode_q on entry; no POP means the stack was empty.
                if (opcode_q != OP_POP) begin
                    uflow_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wait_d  = WAIT_W'(POP_LAT);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wait_d = wait_q - 1'b1;
                if (wait_q == WAIT_W'(1)) begin
                    m_data_d  = lifo_dout;
                    m_valid_d = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    m_valid_d   = 1'b0;
                    remaining_d = remaining_q - 1'b1;
                    state_d     = (remaining_q == CW'(1)) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                uflow_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered opcode: POP is asserted for the whole ISSUE cycle, so decide it on entry.
        if (state_d == ST_ISSUE && !empty) begin
            opcode_d = OP_POP;
        end
        if (state_d == ST_DONE) begin
            done_d      = 1'b1;
            underflow_d = uflow_d;
        end
    end

    assign opcode    = opcode_q;
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign busy_full = busy_full_q;
    assign done      = done_q;
    assign underflow = underflow_q;

endmodule
